// File: rtl/eth_xmii_tx_serializer_pkg.sv
// Shared constants for the xMII transmit serializer: PHY symbol widths and the
// default 10 Mb/s symbol repeat count.
package eth_xmii_tx_serializer_pkg;

    localparam int BYTE_WIDTH          = 8;
    localparam int PHY_WIDTH_RMII      = 2;
    localparam int PHY_WIDTH_MII       = 4;
    localparam int SLOW_REPEAT_DEFAULT = 10;

    function automatic int syms_per_byte(input int phy_width);
        return BYTE_WIDTH / phy_width;
    endfunction

endpackage

// File: rtl/eth_xmii_tx_serializer.sv
// Byte-to-symbol transmit serializer: 8-bit AXI-stream frame in, RMII/MII TXD/TX_EN out,
// with per-frame 10/100 repeat, inter-frame gap timing and mid-frame underflow abort.
//
//  state  | meaning
//  IDLE   | waiting for the first byte of a frame; tready high
//  DATA   | shifting the current byte out, each symbol held rep_top+1 cycles
//  DROP   | frame aborted by underflow; swallow bytes up to and including tlast
//  IFG    | inter-frame gap, ifg_delay byte times at the frame's speed
module eth_xmii_tx_serializer
    import eth_xmii_tx_serializer_pkg::*;
#(
    parameter int PHY_DATA_WIDTH = PHY_WIDTH_RMII,
    parameter int SLOW_REPEAT    = SLOW_REPEAT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tuser,
    output logic [PHY_DATA_WIDTH-1:0] phy_txd,
    output logic                      phy_tx_en,
    output logic                      phy_tx_er,
    input  logic                      speed_10m,
    input  logic [7:0]                ifg_delay,
    output logic                      tx_error_underflow
);

    localparam int SYM   = syms_per_byte(PHY_DATA_WIDTH);
    localparam int SYM_W = (SYM > 1) ? $clog2(SYM) : 1;
    localparam int REP_W = (SLOW_REPEAT > 1) ? $clog2(SLOW_REPEAT) : 1;

    localparam logic [SYM_W-1:0] SYM_LAST      = SYM_W'(SYM - 1);
    localparam logic [REP_W-1:0] REP_SLOW_LAST = REP_W'(SLOW_REPEAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_DROP = 2'd2,
        S_IFG  = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [7:0]         shift, shift_n;
    logic               cur_user, user_n;
    logic               cur_last, last_n;
    logic [REP_W-1:0]   rep_top, rep_top_n;
    logic [REP_W-1:0]   rep_cnt, rep_n;
    logic [SYM_W-1:0]   sym_cnt, sym_n;
    logic [7:0]         byte_cnt, byte_n;
    logic               tready_c;
    logic               underflow_c;
    logic               enter_gap;

    // Counters run down to zero; a byte time ends when both rep and sym reach zero.
    always_comb begin
        state_n     = state;
        shift_n     = shift;
        user_n      = cur_user;
        last_n      = cur_last;
        rep_top_n   = rep_top;
        rep_n       = rep_cnt;
        sym_n       = sym_cnt;
        byte_n      = byte_cnt;
        tready_c    = 1'b0;
        underflow_c = 1'b0;
        enter_gap   = 1'b0;

        case (state)
            S_IDLE: begin
                tready_c = 1'b1;
                if (s_axis_tvalid) begin
                    rep_top_n = speed_10m ? REP_SLOW_LAST : '0;
                    rep_n     = rep_top_n;
                    sym_n     = SYM_LAST;
                    shift_n   = s_axis_tdata;
                    user_n    = s_axis_tuser;
                    last_n    = s_axis_tlast;
                    state_n   = S_DATA;
                end
            end
            S_DATA: begin
                if (rep_cnt != '0) begin
                    rep_n = rep_cnt - REP_W'(1);
                end else if (sym_cnt != '0) begin
                    rep_n   = rep_top;
                    sym_n   = sym_cnt - SYM_W'(1);
                    shift_n = shift >> PHY_DATA_WIDTH;
                end else if (cur_last) begin
                    enter_gap = 1'b1;
                end else begin
                    tready_c = 1'b1;
                    if (s_axis_tvalid) begin
                        rep_n   = rep_top;
                        sym_n   = SYM_LAST;
                        shift_n = s_axis_tdata;
                        user_n  = s_axis_tuser;
                        last_n  = s_axis_tlast;
                    end else begin
                        underflow_c = 1'b1;
                        state_n     = S_DROP;
                    end
                end
            end
            S_DROP: begin
                tready_c = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    enter_gap = 1'b1;
                end
            end
            S_IFG: begin
                if (rep_cnt != '0) begin
                    rep_n = rep_cnt - REP_W'(1);
                end else if (sym_cnt != '0) begin
                    rep_n = rep_top;
                    sym_n = sym_cnt - SYM_W'(1);
                end else if (byte_cnt == 8'd1) begin
                    state_n = S_IDLE;
                end else begin
                    rep_n  = rep_top;
                    sym_n  = SYM_LAST;
                    byte_n = byte_cnt - 8'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // The gap reuses the byte/sym/rep counters so its length needs no multiplier.
        if (enter_gap) begin
            if (ifg_delay == 8'd0) begin
                state_n = S_IDLE;
            end else begin
                state_n = S_IFG;
                byte_n  = ifg_delay;
                sym_n   = SYM_LAST;
                rep_n   = rep_top;
            end
        end
    end

    assign s_axis_tready = tready_c && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_IDLE;
            shift              <= '0;
            cur_user           <= 1'b0;
            cur_last           <= 1'b0;
            rep_top            <= '0;
            rep_cnt            <= '0;
            sym_cnt            <= '0;
            byte_cnt           <= '0;
            phy_txd            <= '0;
            phy_tx_en          <= 1'b0;
            phy_tx_er          <= 1'b0;
            tx_error_underflow <= 1'b0;
        end else begin
            state              <= state_n;
            shift              <= shift_n;
            cur_user           <= user_n;
            cur_last           <= last_n;
            rep_top            <= rep_top_n;
            rep_cnt            <= rep_n;
            sym_cnt            <= sym_n;
            byte_cnt           <= byte_n;
            phy_tx_en          <= (state_n == S_DATA);
            phy_txd            <= (state_n == S_DATA) ? shift_n[PHY_DATA_WIDTH-1:0] : '0;
            phy_tx_er          <= (state_n == S_DATA) && user_n;
            tx_error_underflow <= underflow_c;
        end
    end

endmodule
